// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause bit positions and ExcCodes.
package cp0_regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned INT_W  = 6;
   localparam int unsigned CODE_W = 5;

   localparam logic [ADDR_W-1:0] CP0_SR    = 5'd12;
   localparam logic [ADDR_W-1:0] CP0_CAUSE = 5'd13;
   localparam logic [ADDR_W-1:0] CP0_EPC   = 5'd14;
   localparam logic [ADDR_W-1:0] CP0_PRID  = 5'd15;

   localparam int unsigned SR_IE_BIT  = 0;
   localparam int unsigned SR_EXL_BIT = 1;
   localparam int unsigned SR_IM_LO   = 10;
   localparam int unsigned SR_IM_HI   = 15;

   localparam int unsigned CAUSE_CODE_LO = 2;
   localparam int unsigned CAUSE_CODE_HI = 6;
   localparam int unsigned CAUSE_IP_LO   = 10;
   localparam int unsigned CAUSE_IP_HI   = 15;
   localparam int unsigned CAUSE_BD_BIT  = 31;

   localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
   localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
   localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
   localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

   // Word-align an address by clearing its two low bits.
   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
      return {a[DATA_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// WB-stage CP0 access, exception-commit and interrupt signals between pipeline and CP0.
interface cp0_regfile_if;
   import cp0_regfile_pkg::*;

   logic                 isMTC0W;
   logic                 isMFC0W;
   logic [ADDR_W-1:0]    cp0_addr;
   logic [DATA_W-1:0]    wdata;
   logic [DATA_W-1:0]    rdata;
   logic [INT_W-1:0]     hw_int;
   logic                 exc_enter;
   logic [CODE_W-1:0]    exc_code;
   logic [DATA_W-1:0]    exc_pc;
   logic                 exc_bd;
   logic                 eret;
   logic                 int_req;
   logic [DATA_W-1:0]    epc_out;
   logic                 exl_out;

   modport master (
      output isMTC0W, isMFC0W, cp0_addr, wdata, hw_int,
             exc_enter, exc_code, exc_pc, exc_bd, eret,
      input  rdata, int_req, epc_out, exl_out
   );

   modport slave (
      input  isMTC0W, isMFC0W, cp0_addr, wdata, hw_int,
             exc_enter, exc_code, exc_pc, exc_bd, eret,
      output rdata, int_req, epc_out, exl_out
   );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: SR/Cause/EPC/PRId, interrupt request and
// exception entry / ERET state updates. Priority: exc_enter > eret > MTC0.
module cp0_regfile
   import cp0_regfile_pkg::*;
#(
   parameter logic [31:0] PRID      = 32'h4D49_5053,
   parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset,
   cp0_regfile_if.slave bus
);

   logic [INT_W-1:0]  sr_im;
   logic              sr_exl;
   logic              sr_ie;
   logic [INT_W-1:0]  cause_ip;
   logic              cause_bd;
   logic [CODE_W-1:0] cause_code;
   logic [DATA_W-1:0] epc;

   logic              wr_sr;
   logic              wr_epc;
   logic [DATA_W-1:0] exc_target;
   logic [DATA_W-1:0] sr_word;
   logic [DATA_W-1:0] cause_word;
   logic              unused_wdata;

   assign wr_sr      = bus.isMTC0W && (bus.cp0_addr == CP0_SR);
   assign wr_epc     = bus.isMTC0W && (bus.cp0_addr == CP0_EPC);
   assign exc_target = bus.exc_bd ? (bus.exc_pc - DATA_W'(4)) : bus.exc_pc;

   // Only IM/EXL/IE are stored; the remaining write-data bits are discarded.
   assign unused_wdata = ^{bus.wdata[31:16], bus.wdata[9:2]};

   // SR: EXL follows exc_enter > eret > MTC0; IM/IE are only written by MTC0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im  <= '0;
         sr_exl <= 1'b0;
         sr_ie  <= 1'b0;
      end else begin
         if (wr_sr) begin
            sr_im <= bus.wdata[SR_IM_HI:SR_IM_LO];
            sr_ie <= bus.wdata[SR_IE_BIT];
         end
         if (bus.exc_enter)
            sr_exl <= 1'b1;
         else if (bus.eret)
            sr_exl <= 1'b0;
         else if (wr_sr)
            sr_exl <= bus.wdata[SR_EXL_BIT];
      end
   end

   // Cause: IP samples hw_int every cycle; BD/ExcCode load on exception entry only.
   always_ff @(posedge clk) begin
      if (reset) begin
         cause_ip   <= '0;
         cause_bd   <= 1'b0;
         cause_code <= '0;
      end else begin
         cause_ip <= bus.hw_int;
         if (bus.exc_enter) begin
            cause_bd   <= bus.exc_bd;
            cause_code <= bus.exc_code;
         end
      end
   end

   // EPC: exception entry overrides a same-cycle MTC0.
   always_ff @(posedge clk) begin
      if (reset)
         epc <= EPC_RESET;
      else if (bus.exc_enter)
         epc <= word_align(exc_target);
      else if (wr_epc)
         epc <= word_align(bus.wdata);
   end

   always_comb begin
      sr_word                       = '0;
      sr_word[SR_IM_HI:SR_IM_LO]    = sr_im;
      sr_word[SR_EXL_BIT]           = sr_exl;
      sr_word[SR_IE_BIT]            = sr_ie;
      cause_word                             = '0;
      cause_word[CAUSE_BD_BIT]               = cause_bd;
      cause_word[CAUSE_IP_HI:CAUSE_IP_LO]    = cause_ip;
      cause_word[CAUSE_CODE_HI:CAUSE_CODE_LO] = cause_code;
   end

   // Read mux returns pre-edge register state.
   always_comb begin
      bus.rdata = '0;
      if (bus.isMFC0W) begin
         unique case (bus.cp0_addr)
            CP0_SR:    bus.rdata = sr_word;
            CP0_CAUSE: bus.rdata = cause_word;
            CP0_EPC:   bus.rdata = epc;
            CP0_PRID:  bus.rdata = PRID;
            default:   bus.rdata = '0;
         endcase
      end
   end

   assign bus.int_req = sr_ie & ~sr_exl & (|(cause_ip & sr_im));
   assign bus.epc_out = epc;
   assign bus.exl_out = sr_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;
   import cp0_regfile_pkg::*;

   localparam logic [31:0] PRID_V = 32'h4D49_5053;
   localparam logic [31:0] EPC_RV = 32'h0000_0000;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   cp0_regfile_if bus ();

   cp0_regfile #(.PRID(PRID_V), .EPC_RESET(EPC_RV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.isMTC0W   = 1'b0;
      bus.isMFC0W   = 1'b0;
      bus.cp0_addr  = '0;
      bus.wdata     = '0;
      bus.exc_enter = 1'b0;
      bus.exc_code  = '0;
      bus.exc_pc    = '0;
      bus.exc_bd    = 1'b0;
      bus.eret      = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      bus.isMFC0W  = 1'b1;
      bus.cp0_addr = a;
      #1;
      v = bus.rdata;
      bus.isMFC0W  = 1'b0;
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.isMTC0W  = 1'b1;
      bus.cp0_addr = a;
      bus.wdata    = d;
   endtask

   task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code);
      bus.exc_enter = 1'b1;
      bus.exc_pc    = pc;
      bus.exc_bd    = bd;
      bus.exc_code  = code;
   endtask

   logic [31:0] v;

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.hw_int = '0;
      idle();
      tick(); tick();
      reset = 1'b0;

      // Reset state
      rd(CP0_SR, v);    chk("rst_sr", v, 32'h0);
      rd(CP0_CAUSE, v); chk("rst_cause", v, 32'h0);
      rd(CP0_EPC, v);   chk("rst_epc", v, EPC_RV);
      rd(CP0_PRID, v);  chk("rst_prid", v, PRID_V);
      chk("rst_int_req", 32'(bus.int_req), 32'h0);
      chk("rst_exl", 32'(bus.exl_out), 32'h0);
      chk("rst_epc_out", bus.epc_out, EPC_RV);

      // Enable IM[10] and IE, then raise hw_int[0]
      mtc0(CP0_SR, 32'h0000_0401);
      tick(); idle();
      rd(CP0_SR, v); chk("sr_write", v, 32'h0000_0401);
      bus.hw_int = 6'b000001;
      #1;
      chk("int_req_before_sample", 32'(bus.int_req), 32'h0);
      tick();
      rd(CP0_CAUSE, v); chk("cause_ip", v, 32'h0000_0400);
      chk("int_req_raised", 32'(bus.int_req), 32'h1);

      // Interrupt entry, not in delay slot
      exc(32'h0000_3010, 1'b0, EXC_INT);
      tick(); idle();
      chk("exc_epc", bus.epc_out, 32'h0000_3010);
      chk("exc_exl", 32'(bus.exl_out), 32'h1);
      chk("exc_int_req", 32'(bus.int_req), 32'h0);
      rd(CP0_CAUSE, v); chk("exc_cause", v, 32'h0000_0400);
      rd(CP0_SR, v);    chk("exc_sr", v, 32'h0000_0403);

      // ERET re-arms the interrupt while hw_int is held
      bus.eret = 1'b1;
      tick(); idle();
      chk("eret_exl", 32'(bus.exl_out), 32'h0);
      chk("eret_int_req", 32'(bus.int_req), 32'h1);
      chk("eret_epc", bus.epc_out, 32'h0000_3010);

      // Delay-slot RI exception: EPC points at the branch
      exc(32'h0000_3014, 1'b1, EXC_RI);
      tick(); idle();
      chk("bd_epc", bus.epc_out, 32'h0000_3010);
      rd(CP0_CAUSE, v); chk("bd_cause", v, 32'h8000_0428);
      bus.eret = 1'b1;
      tick(); idle();

      // Exception entry beats same-cycle MTC0 to EPC
      exc(32'h0000_3020, 1'b0, EXC_ADEL);
      mtc0(CP0_EPC, 32'h0000_4000);
      tick(); idle();
      chk("exc_over_mtc0_epc", bus.epc_out, 32'h0000_3020);
      rd(CP0_CAUSE, v); chk("adel_cause", v, 32'h0000_0410);

      // Cause and PRId ignore MTC0
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      tick(); idle();
      rd(CP0_CAUSE, v); chk("cause_ro", v, 32'h0000_0410);
      mtc0(CP0_PRID, 32'h1234_5678);
      tick(); idle();
      rd(CP0_PRID, v); chk("prid_ro", v, PRID_V);

      // MTC0 EPC aligns and reads see pre-edge value
      mtc0(CP0_EPC, 32'h0000_5003);
      bus.isMFC0W = 1'b1;
      #1;
      chk("no_bypass", bus.rdata, 32'h0000_3020);
      tick(); idle();
      chk("epc_align", bus.epc_out, 32'h0000_5000);

      // eret + MTC0 SR: IM/IE from wdata, EXL cleared
      bus.eret = 1'b1;
      mtc0(CP0_SR, 32'h0000_0403);
      tick(); idle();
      rd(CP0_SR, v); chk("eret_mtc0_sr", v, 32'h0000_0401);
      chk("eret_mtc0_int_req", 32'(bus.int_req), 32'h1);

      // Source deassert drops the request
      bus.hw_int = '0;
      tick();
      chk("deassert_int_req", 32'(bus.int_req), 32'h0);
      bus.hw_int = 6'b000001;
      tick();
      chk("reassert_int_req", 32'(bus.int_req), 32'h1);

      // exc_enter + MTC0 SR: IM/IE from wdata, EXL forced to 1
      exc(32'h0000_3030, 1'b0, EXC_OV);
      mtc0(CP0_SR, 32'h0000_0800);
      tick(); idle();
      rd(CP0_SR, v); chk("exc_mtc0_sr", v, 32'h0000_0802);
      chk("exc_mtc0_epc", bus.epc_out, 32'h0000_3030);

      // Unimplemented address and unqualified read return 0
      rd(5'd3, v); chk("unimpl_read", v, 32'h0);
      bus.cp0_addr = CP0_PRID;
      #1;
      chk("no_mfc0_read", bus.rdata, 32'h0);

      // Restore an active interrupt, then reset mid-interrupt
      mtc0(CP0_SR, 32'h0000_0401);
      tick(); idle();
      chk("pre_reset_int_req", 32'(bus.int_req), 32'h1);
      reset = 1'b1;
      exc(32'h0000_3040, 1'b1, EXC_ADES);
      mtc0(CP0_SR, 32'h0000_0401);
      tick(); idle();
      reset = 1'b0;
      rd(CP0_SR, v);    chk("reset_sr", v, 32'h0);
      rd(CP0_CAUSE, v); chk("reset_cause", v, 32'h0);
      chk("reset_int_req", 32'(bus.int_req), 32'h0);
      chk("reset_epc", bus.epc_out, EPC_RV);
      tick();
      rd(CP0_CAUSE, v); chk("resample_ip", v, 32'h0000_0400);
      chk("post_reset_int_req", 32'(bus.int_req), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
